// File: rtl/vae_io_buffer_ctrl.sv
// rtl/vae_io_buffer_ctrl.sv - parameter/result buffer and start/done sequencer for the VAE forward core
module vae_io_buffer_ctrl #(
   parameter  int DATA_W    = 64,
   parameter  int LANE_W    = 16,
   parameter  int NUM_PARAM = 76,
   parameter  int NUM_OUT   = 9,
   localparam int LANES     = DATA_W / LANE_W,
   localparam int IN_DEPTH  = (NUM_PARAM + LANES - 1) / LANES,
   localparam int OUT_DEPTH = (NUM_OUT + LANES - 1) / LANES,
   localparam int IN_AW     = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1,
   localparam int OUT_AW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [IN_AW-1:0]              wr_addr,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic                          clear,
   input  logic                          rerun,
   output logic [NUM_PARAM*LANE_W-1:0]   param_flat,
   output logic                          core_start,
   input  logic                          core_done,
   input  logic [NUM_OUT*LANE_W-1:0]     result_flat,
   input  logic                          rd_en,
   input  logic [OUT_AW-1:0]             rd_addr,
   output logic [DATA_W-1:0]             rd_data,
   output logic                          rd_valid,
   output logic                          busy,
   output logic                          result_ready,
   output logic                          err_flag
);

   localparam int OUT_PAD_W = OUT_DEPTH * DATA_W;

   typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_DONE} state_t;

   state_t                 state;
   logic [DATA_W-1:0]      in_buf  [IN_DEPTH];
   logic [DATA_W-1:0]      out_buf [OUT_DEPTH];
   logic [IN_DEPTH-1:0]    word_valid;
   logic [OUT_PAD_W-1:0]   result_pad;
   logic                   wr_open;
   logic                   wr_in_range;
   logic                   wr_accept;
   logic                   rd_in_range;

   // Zero-extension pads the unused lanes of the last result word with 0.
   assign result_pad  = OUT_PAD_W'(result_flat);
   assign wr_open     = (state == S_LOAD) || (state == S_DONE);
   assign wr_in_range = int'(wr_addr) < IN_DEPTH;
   assign wr_accept   = wr_en && wr_open && wr_in_range;
   assign rd_in_range = int'(rd_addr) < OUT_DEPTH;

   // Flatten buffer words into lanes for the core.
   for (genvar i = 0; i < NUM_PARAM; i++) begin : g_param
      assign param_flat[i*LANE_W +: LANE_W] = in_buf[i / LANES][(i % LANES)*LANE_W +: LANE_W];
   end

   // Parameter buffer: accepted writes overwrite the addressed word.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < IN_DEPTH; i++) in_buf[i] <= '0;
      end else if (wr_accept) begin
         in_buf[wr_addr] <= wr_data;
      end
   end

   // Sequencer: load tracking, start pulse, result capture, clear/rerun and error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_LOAD;
         word_valid   <= '0;
         core_start   <= 1'b0;
         busy         <= 1'b0;
         result_ready <= 1'b0;
         err_flag     <= 1'b0;
         for (int w = 0; w < OUT_DEPTH; w++) out_buf[w] <= '0;
      end else begin
         if (wr_en && !(wr_open && wr_in_range)) err_flag <= 1'b1;
         if (clear) begin
            // Abandons any run in flight; a late core_done lands in LOAD and is ignored.
            state        <= S_LOAD;
            word_valid   <= '0;
            core_start   <= 1'b0;
            busy         <= 1'b0;
            result_ready <= 1'b0;
         end else begin
            if (wr_accept) word_valid[wr_addr] <= 1'b1;
            case (state)
               S_LOAD: begin
                  if (&word_valid) begin
                     state      <= S_START;
                     core_start <= 1'b1;
                     busy       <= 1'b1;
                  end
               end
               S_START: begin
                  state      <= S_WAIT;
                  core_start <= 1'b0;
               end
               S_WAIT: begin
                  if (core_done) begin
                     state        <= S_DONE;
                     busy         <= 1'b0;
                     result_ready <= 1'b1;
                     for (int w = 0; w < OUT_DEPTH; w++)
                        out_buf[w] <= result_pad[w*DATA_W +: DATA_W];
                  end
               end
               S_DONE: begin
                  if (rerun) begin
                     state        <= S_START;
                     core_start   <= 1'b1;
                     busy         <= 1'b1;
                     result_ready <= 1'b0;
                  end
               end
               default: state <= S_LOAD;
            endcase
         end
      end
   end

   // Result read port: one-cycle registered read, out-of-range words read as 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_data <= rd_in_range ? out_buf[rd_addr] : '0;
      end
   end

endmodule

// File: tb/tb_vae_io_buffer_ctrl.sv
// tb/tb_vae_io_buffer_ctrl.sv - self-checking bench for vae_io_buffer_ctrl
module tb_vae_io_buffer_ctrl;
   localparam int NP = 76;
   localparam int NO = 9;
   localparam int LW = 16;
   localparam int ND = 19;
   localparam int OD = 3;
   localparam int PW = NP * LW;
   localparam int P_LOAD = 0, P_START = 1, P_WAIT = 2, P_DONE = 3;

   logic              clk = 1'b0;
   logic              rst, wr_en, clear, rerun, core_done, rd_en;
   logic [4:0]        wr_addr;
   logic [63:0]       wr_data;
   logic [1:0]        rd_addr;
   logic [PW-1:0]     param_flat;
   logic              core_start;
   logic [NO*LW-1:0]  result_flat;
   logic [63:0]       rd_data;
   logic              rd_valid, busy, result_ready, err_flag;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          m_ph;
   logic [63:0] m_buf [ND];
   bit          m_ld  [ND];
   logic [63:0] m_out [OD];
   logic [63:0] m_rd;
   bit          m_rv;
   bit          m_err;

   typedef struct {
      logic        en;
      logic [1:0]  addr;
      logic        exp_valid;
      logic [63:0] exp_data;
   } rd_vec_t;
   rd_vec_t rd_tab [7];

   always #5 clk = ~clk;

   vae_io_buffer_ctrl dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .clear(clear), .rerun(rerun), .param_flat(param_flat), .core_start(core_start),
      .core_done(core_done), .result_flat(result_flat), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .result_ready(result_ready),
      .err_flag(err_flag)
   );

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] model_param();
      logic [PW-1:0] f;
      for (int i = 0; i < NP; i++) f[i*LW +: LW] = m_buf[i / 4][(i % 4)*LW +: LW];
      return f;
   endfunction

   task automatic model_step();
      int ph0;
      bit all_loaded;
      if (rst) begin
         m_ph = P_LOAD; m_rd = '0; m_rv = 0; m_err = 0;
         for (int i = 0; i < ND; i++) begin m_buf[i] = '0; m_ld[i] = 0; end
         for (int w = 0; w < OD; w++) m_out[w] = '0;
         return;
      end
      ph0 = m_ph;
      all_loaded = 1;
      for (int i = 0; i < ND; i++) if (!m_ld[i]) all_loaded = 0;
      m_rv = rd_en;
      if (rd_en) m_rd = (int'(rd_addr) < OD) ? m_out[rd_addr] : 64'h0;
      if (wr_en) begin
         if ((ph0 == P_LOAD || ph0 == P_DONE) && int'(wr_addr) < ND) begin
            m_buf[wr_addr] = wr_data;
            m_ld[wr_addr]  = 1;
         end else begin
            m_err = 1;
         end
      end
      if (clear) begin
         for (int i = 0; i < ND; i++) m_ld[i] = 0;
         m_ph = P_LOAD;
      end else begin
         case (ph0)
            P_LOAD:  if (all_loaded) m_ph = P_START;
            P_START: m_ph = P_WAIT;
            P_WAIT:  if (core_done) begin
               m_ph = P_DONE;
               for (int j = 0; j < 4*OD; j++)
                  m_out[j / 4][(j % 4)*LW +: LW] = (j < NO) ? result_flat[j*LW +: LW] : 16'h0;
            end
            default: if (rerun) m_ph = P_START;
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("m_core_start", PW'(core_start),   PW'(m_ph == P_START));
      chk("m_busy",       PW'(busy),         PW'(m_ph == P_START || m_ph == P_WAIT));
      chk("m_ready",      PW'(result_ready), PW'(m_ph == P_DONE));
      chk("m_err",        PW'(err_flag),     PW'(m_err));
      chk("m_rd_valid",   PW'(rd_valid),     PW'(m_rv));
      chk("m_rd_data",    PW'(rd_data),      PW'(m_rd));
      chk("m_param",      param_flat,        model_param());
   endtask

   task automatic idle();
      rst = 0; wr_en = 0; clear = 0; rerun = 0; core_done = 0; rd_en = 0;
   endtask

   task automatic wr(input int a, input logic [63:0] d);
      wr_en = 1; wr_addr = 5'(a); wr_data = d;
      tick();
      wr_en = 0;
   endtask

   initial begin
      logic [63:0] w;
      int seq;
      rd_tab[0] = '{1'b1, 2'd2, 1'b1, 64'h0000_0000_0000_0108};
      rd_tab[1] = '{1'b1, 2'd0, 1'b1, 64'h0103_0102_0101_0100};
      rd_tab[2] = '{1'b1, 2'd1, 1'b1, 64'h0107_0106_0105_0104};
      rd_tab[3] = '{1'b1, 2'd3, 1'b1, 64'h0};
      rd_tab[4] = '{1'b0, 2'd1, 1'b0, 64'h0};
      rd_tab[5] = '{1'b1, 2'd2, 1'b1, 64'h0000_0000_0000_0108};
      rd_tab[6] = '{1'b0, 2'd0, 1'b0, 64'h0000_0000_0000_0108};

      idle(); rst = 1; wr_addr = '0; wr_data = '0; rd_addr = '0; result_flat = '0;
      tick(); tick();
      rst = 0;
      chk("reset_start", PW'(core_start), PW'(1'b0));
      chk("reset_busy",  PW'(busy),       PW'(1'b0));
      chk("reset_err",   PW'(err_flag),   PW'(1'b0));
      chk("reset_param", param_flat,      PW'(0));

      // load all words in order; start two cycles after the last write
      for (int k = 0; k < ND; k++) begin
         wr(k, {4{16'(k)}});
         chk("load_no_start", PW'(core_start), PW'(1'b0));
      end
      tick();
      chk("start_pulse", PW'(core_start), PW'(1'b1));
      chk("lane5", PW'(param_flat[5*LW +: LW]), PW'(16'h0001));
      tick();
      chk("start_once", PW'(core_start), PW'(1'b0));
      chk("busy_wait",  PW'(busy),       PW'(1'b1));

      // results captured on core_done
      for (int j = 0; j < NO; j++) result_flat[j*LW +: LW] = 16'(16'h0100 + j);
      core_done = 1; tick(); core_done = 0;
      chk("ready", PW'(result_ready), PW'(1'b1));

      for (int i = 0; i < 7; i++) begin
         rd_en = rd_tab[i].en; rd_addr = rd_tab[i].addr;
         tick();
         chk("tab_rd_valid", PW'(rd_valid), PW'(rd_tab[i].exp_valid));
         chk("tab_rd_data",  PW'(rd_data),  PW'(rd_tab[i].exp_data));
      end
      rd_en = 0;

      // write together with rerun: START sees the new word
      rerun = 1; wr(0, 64'hAAAA_BBBB_CCCC_DDDD); rerun = 0;
      chk("rerun_start", PW'(core_start), PW'(1'b1));
      chk("rerun_lane0", PW'(param_flat[15:0]), PW'(16'hDDDD));
      chk("rerun_word1", PW'(param_flat[127:64]), PW'({4{16'h0001}}));
      tick();
      wr(2, 64'hDEAD_BEEF_0000_1111);
      chk("wait_wr_err",  PW'(err_flag), PW'(1'b1));
      chk("wait_wr_drop", PW'(param_flat[191:128]), PW'({4{16'h0002}}));
      core_done = 1; tick(); core_done = 0;

      // clear beats rerun
      clear = 1; rerun = 1; tick(); clear = 0; rerun = 0;
      chk("clr_ready", PW'(result_ready), PW'(1'b0));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("clr_no_start", PW'(core_start), PW'(1'b0));
      end

      // reverse load, word 7 twice, word 3 held back
      for (int k = ND - 1; k >= 0; k--) begin
         if (k == 3) continue;
         if (k == 7) wr(7, 64'h1111_1111_1111_1111);
         wr(k, (k == 7) ? 64'h7777_0007_7777_0007 : {4{16'(k + 32)}});
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("partial_no_start", PW'(core_start), PW'(1'b0));
      end
      wr(3, {4{16'h0023}});
      tick();
      chk("word3_start", PW'(core_start), PW'(1'b1));
      chk("word7_second", PW'(param_flat[7*64 +: 64]), PW'(64'h7777_0007_7777_0007));
      tick();

      // reset in WAIT: later core_done must not capture
      rst = 1; tick(); rst = 0;
      for (int j = 0; j < NO; j++) result_flat[j*LW +: LW] = 16'hFFFF;
      core_done = 1; tick(); core_done = 0;
      chk("rst_ready", PW'(result_ready), PW'(1'b0));
      rd_en = 1; rd_addr = 2'd0; tick(); rd_en = 0;
      chk("rst_no_capture", PW'(rd_data), PW'(64'h0));

      // out-of-range write in LOAD
      wr(19, 64'h5555_5555_5555_5555);
      chk("oob_err",   PW'(err_flag), PW'(1'b1));
      chk("oob_param", param_flat,    PW'(0));
      tick(); tick();
      chk("err_sticky", PW'(err_flag), PW'(1'b1));

      // randomized run against the model
      seq = 0;
      for (int c = 0; c < 3000; c++) begin
         rst   = ($urandom_range(0, 399) == 0);
         wr_en = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 1) == 1) begin
            wr_addr = 5'(seq % 21); seq++;
         end else begin
            wr_addr = 5'($urandom_range(0, 20));
         end
         w = {$urandom, $urandom};
         wr_data   = w;
         clear     = ($urandom_range(0, 199) == 0);
         rerun     = ($urandom_range(0, 9) == 0);
         core_done = ($urandom_range(0, 4) == 0);
         rd_en     = ($urandom_range(0, 1) == 1);
         rd_addr   = 2'($urandom_range(0, 3));
         for (int j = 0; j < NO; j++) result_flat[j*LW +: LW] = 16'($urandom);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
